// File: rtl/box_draw_arbiter.sv
// ============================================================================
// box_draw_arbiter: round-robin share of the VGA pixel port between three box
// requesters, expanding each granted box into raster-order pixel writes.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module box_draw_arbiter #(
  parameter int BOX_W = 4,
  parameter int BOX_H = 4,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [7:0] x0,
  input  logic [7:0] x1,
  input  logic [7:0] x2,
  input  logic [6:0] y0,
  input  logic [6:0] y1,
  input  logic [6:0] y2,
  input  logic [2:0] c0,
  input  logic [2:0] c1,
  input  logic [2:0] c2,
  output logic [2:0] ack,
  output logic       busy,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  localparam logic [2:0] c_DX_LAST = 3'(BOX_W - 1);
  localparam logic [2:0] c_DY_LAST = 3'(BOX_H - 1);
  localparam logic [8:0] c_X_MAX   = 9'(X_MAX);
  localparam logic [7:0] c_Y_MAX   = 8'(Y_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  logic [1:0] r_last_grant;
  logic [1:0] r_grant;
  logic [7:0] r_bx;
  logic [6:0] r_by;
  logic [2:0] r_bc;
  logic [2:0] r_dx;
  logic [2:0] r_dy;

  logic [1:0] w_win;
  logic [7:0] w_sel_x;
  logic [6:0] w_sel_y;
  logic [2:0] w_sel_c;
  logic [8:0] w_sx;
  logic [7:0] w_sy;
  logic       w_visible;

  // Search starts just after the last winner, so a re-raised request ranks lowest.
  always_comb begin
    w_win = 2'd0;
    case (r_last_grant)
      2'd0: begin
        if (req[1])      w_win = 2'd1;
        else if (req[2]) w_win = 2'd2;
        else             w_win = 2'd0;
      end
      2'd1: begin
        if (req[2])      w_win = 2'd2;
        else if (req[0]) w_win = 2'd0;
        else             w_win = 2'd1;
      end
      default: begin
        if (req[0])      w_win = 2'd0;
        else if (req[1]) w_win = 2'd1;
        else             w_win = 2'd2;
      end
    endcase
  end

  always_comb begin
    w_sel_x = x0;
    w_sel_y = y0;
    w_sel_c = c0;
    case (w_win)
      2'd1: begin
        w_sel_x = x1;
        w_sel_y = y1;
        w_sel_c = c1;
      end
      2'd2: begin
        w_sel_x = x2;
        w_sel_y = y2;
        w_sel_c = c2;
      end
      default: ;
    endcase
  end

  // Wide sums let off-screen pixels be suppressed instead of wrapping around.
  assign w_sx      = 9'(r_bx) + 9'(r_dx);
  assign w_sy      = 8'(r_by) + 8'(r_dy);
  assign w_visible = (w_sx <= c_X_MAX) && (w_sy <= c_Y_MAX);
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 2'd2;
      r_grant      <= 2'd0;
      r_bx         <= '0;
      r_by         <= '0;
      r_bc         <= '0;
      r_dx         <= '0;
      r_dy         <= '0;
      ack          <= '0;
      vga_x        <= '0;
      vga_y        <= '0;
      vga_colour   <= '0;
      vga_plot     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          ack      <= '0;
          vga_plot <= 1'b0;
          if (req != 3'b000) begin
            r_grant <= w_win;
            r_bx    <= w_sel_x;
            r_by    <= w_sel_y;
            r_bc    <= w_sel_c;
            r_dx    <= '0;
            r_dy    <= '0;
            r_state <= S_DRAW;
          end
        end
        S_DRAW: begin
          vga_x      <= w_sx[7:0];
          vga_y      <= w_sy[6:0];
          vga_colour <= r_bc;
          vga_plot   <= w_visible;
          if (r_dx == c_DX_LAST) begin
            r_dx <= '0;
            if (r_dy == c_DY_LAST) begin
              ack     <= 3'b001 << r_grant;
              r_state <= S_DONE;
            end else begin
              r_dy <= r_dy + 3'd1;
            end
          end else begin
            r_dx <= r_dx + 3'd1;
          end
        end
        S_DONE: begin
          ack          <= '0;
          vga_plot     <= 1'b0;
          r_last_grant <= r_grant;
          r_state      <= S_IDLE;
        end
        default: begin
          ack      <= '0;
          vga_plot <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
